// File: rtl/packet_pkg.sv
// packet_pkg: definitions shared by the packet receive/execute/transmit path.
//   SYNC_BYTE    - first byte of every frame
//   MAX_PAYLOAD  - payload buffer depth (bytes)
//   RESP_ERR/OK  - response codes produced by the command executor
//   frame_state_t - transmit framer state encoding
package packet_pkg;

   localparam logic [7:0]  SYNC_BYTE   = 8'h55;
   localparam int unsigned MAX_PAYLOAD = 16;

   localparam logic [7:0]  RESP_ERR    = 8'h80;
   localparam logic [7:0]  RESP_OK     = 8'h81;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_CSUM = 3'd4
   } frame_state_t;

endpackage

// File: rtl/packet_tx.sv
// packet_tx: packet framer and byte serializer.
// Latches a response packet (length + 16 payload bytes) on tx_packet_wr and
// streams it as SYNC, len, payload[0..len-1], csum over a valid/ready byte
// interface. csum makes the 8-bit sum of every byte after SYNC equal zero.
// Ports:
//   clk, rst (async, active-low)
//   tx_packet_wr, tx_payload_len, tx_buf0..tx_buf15 : packet input
//   tx_busy      : packet accepted and checksum not yet transferred
//   tx_byte, tx_valid, tx_ready : byte stream handshake
//   tx_drop      : pulse, write ignored while busy
//   tx_len_error : pulse, write rejected because length > MAX_PAYLOAD
//   frames_sent  : completed-frame counter (wraps)
module packet_tx #(
   parameter logic [7:0]  SYNC_BYTE   = packet_pkg::SYNC_BYTE,
   parameter int unsigned MAX_PAYLOAD = packet_pkg::MAX_PAYLOAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_packet_wr,
   input  logic [7:0]  tx_payload_len,
   input  logic [7:0]  tx_buf0,
   input  logic [7:0]  tx_buf1,
   input  logic [7:0]  tx_buf2,
   input  logic [7:0]  tx_buf3,
   input  logic [7:0]  tx_buf4,
   input  logic [7:0]  tx_buf5,
   input  logic [7:0]  tx_buf6,
   input  logic [7:0]  tx_buf7,
   input  logic [7:0]  tx_buf8,
   input  logic [7:0]  tx_buf9,
   input  logic [7:0]  tx_buf10,
   input  logic [7:0]  tx_buf11,
   input  logic [7:0]  tx_buf12,
   input  logic [7:0]  tx_buf13,
   input  logic [7:0]  tx_buf14,
   input  logic [7:0]  tx_buf15,
   output logic        tx_busy,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_drop,
   output logic        tx_len_error,
   output logic [15:0] frames_sent
);

   import packet_pkg::*;

   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   frame_state_t state;
   logic [7:0]   len_q;
   logic [7:0]   sum_q;
   logic [3:0]   idx;
   logic [7:0]   buf_q  [16];
   logic [7:0]   buf_in [16];

   logic       accept;
   logic       xfer;
   logic       last;
   logic [7:0] cur_byte;
   logic [7:0] next_byte;
   logic [7:0] len_sum;
   logic [7:0] data_sum;

   always_comb begin
      buf_in[0]  = tx_buf0;
      buf_in[1]  = tx_buf1;
      buf_in[2]  = tx_buf2;
      buf_in[3]  = tx_buf3;
      buf_in[4]  = tx_buf4;
      buf_in[5]  = tx_buf5;
      buf_in[6]  = tx_buf6;
      buf_in[7]  = tx_buf7;
      buf_in[8]  = tx_buf8;
      buf_in[9]  = tx_buf9;
      buf_in[10] = tx_buf10;
      buf_in[11] = tx_buf11;
      buf_in[12] = tx_buf12;
      buf_in[13] = tx_buf13;
      buf_in[14] = tx_buf14;
      buf_in[15] = tx_buf15;
   end

   always_comb begin
      accept    = tx_packet_wr && !tx_busy && (tx_payload_len <= MAX_LEN);
      xfer      = tx_valid && tx_ready;
      cur_byte  = buf_q[idx];
      // index wraps past 15 only when the frame is on its last byte, where
      // next_byte is not used
      next_byte = buf_q[idx + 4'd1];
      len_sum   = sum_q + len_q;
      data_sum  = sum_q + cur_byte;
      last      = ({4'd0, idx} == (len_q - 8'd1));
   end

   // Payload buffer carries no reset: it is only read after an accept loads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q <= buf_in;
      end
   end

   // tx_byte is always loaded with the byte for the state being entered, so
   // the next byte is ready the cycle after each transfer (no bubble).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         len_q        <= '0;
         sum_q        <= '0;
         idx          <= '0;
         tx_busy      <= 1'b0;
         tx_valid     <= 1'b0;
         tx_byte      <= '0;
         tx_drop      <= 1'b0;
         tx_len_error <= 1'b0;
         frames_sent  <= '0;
      end else begin
         tx_drop      <= tx_packet_wr && tx_busy;
         tx_len_error <= tx_packet_wr && !tx_busy && (tx_payload_len > MAX_LEN);

         case (state)
            S_IDLE: begin
               if (accept) begin
                  state    <= S_SYNC;
                  len_q    <= tx_payload_len;
                  sum_q    <= '0;
                  idx      <= '0;
                  tx_busy  <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_byte  <= SYNC_BYTE;
               end
            end
            S_SYNC: begin
               if (xfer) begin
                  state   <= S_LEN;
                  tx_byte <= len_q;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  sum_q <= len_sum;
                  if (len_q != 8'd0) begin
                     state   <= S_DATA;
                     tx_byte <= cur_byte;
                  end else begin
                     state   <= S_CSUM;
                     tx_byte <= 8'd0 - len_sum;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  sum_q <= data_sum;
                  if (last) begin
                     state   <= S_CSUM;
                     tx_byte <= 8'd0 - data_sum;
                  end else begin
                     idx     <= idx + 4'd1;
                     tx_byte <= next_byte;
                  end
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  state       <= S_IDLE;
                  tx_valid    <= 1'b0;
                  tx_busy     <= 1'b0;
                  frames_sent <= frames_sent + 16'd1;
               end
            end
            default: begin
               state    <= S_IDLE;
               tx_valid <= 1'b0;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
